// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Frame format (parity, stop bits) is captured when a character leaves the FIFO.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          wr,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tbr,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          TxD
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic [TICK_W-1:0]     r_tick;
    logic [BIT_W-1:0]      r_bit;
    logic [1:0]            r_pmode;
    logic                  r_two;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tick_end;
    logic                  w_last_data;
    logic                  w_last_stop;
    logic                  w_txd;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] mode);
        case (mode)
            2'b01:   parity_bit = ^d;
            2'b10:   parity_bit = ~^d;
            default: parity_bit = 1'b1;
        endcase
    endfunction

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push      = wr && !w_full;
    assign w_tick_end  = en && (r_tick == TICK_W'(OVERSAMPLE - 1));
    assign w_last_data = (r_bit == BIT_W'(DATA_BITS - 1));
    // r_bit doubles as the stop-bit index once the data bits are done
    assign w_last_stop = !r_two || (r_bit == BIT_W'(1));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= wr && w_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_txd  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_tick_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_tick_end && w_last_data) begin
                    w_next = (r_pmode != 2'b00) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_txd = r_par;
                if (w_tick_end) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Back-to-back frames: the next start bit begins on this same edge
                if (w_tick_end && w_last_stop) begin
                    if (r_count != '0) begin
                        w_pop  = 1'b1;
                        w_next = S_START;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_pmode <= 2'b00;
            r_two   <= 1'b0;
        end else if (w_pop) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_pmode <= parity_mode;
            r_two   <= two_stop;
        end else if (r_state != S_IDLE && en) begin
            if (w_tick_end) begin
                r_tick <= '0;
                case (r_state)
                    S_DATA:  r_bit <= w_last_data ? '0 : r_bit + 1'b1;
                    S_STOP:  r_bit <= r_bit + 1'b1;
                    default: r_bit <= '0;
                endcase
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_par   <= parity_bit(r_mem[r_rptr], parity_mode);
        end else if (r_state == S_DATA && w_tick_end) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign TxD        = w_txd;
    assign tbr        = !w_full;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued at write time
// and compared bit-period by bit-period by a line monitor.
module tb_uart_tx_cfg;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic       wr;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       tbr;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;
    logic       TxD;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en   = 1'b0;
    bit mon_busy = 1'b0;
    int cyc      = 0;
    int last_end = -100;

    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       ts;
        logic       contig;
    } frame_t;

    frame_t sb[$];

    uart_tx_cfg #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .wr         (wr),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .tbr        (tbr),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .TxD        (TxD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic contig);
        frame_t f;
        f.d      = d;
        f.pm     = parity_mode;
        f.ts     = two_stop;
        f.contig = contig;
        sb.push_back(f);
    endtask

    task automatic wr_one(input logic [7:0] d);
        data = d;
        wr   = 1'b1;
        @(posedge clk); #1;
        wr   = 1'b0;
    endtask

    task automatic send_timed(input string tag, input logic [7:0] d, input int nbits);
        int n;
        n = 0;
        push(d, 1'b0);
        wr_one(d);
        while (busy && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, n, nbits * OS + 1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy || busy) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, int'(sb.size() != 0 || mon_busy || busy), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Line monitor: one comparison per bit period (all OS samples must match)
    initial begin
        frame_t      f;
        logic [15:0] v;
        logic        eb[$];
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !rst && TxD === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    f = sb.pop_front();
                    mon_busy = 1'b1;
                    if (f.contig) chk($sformatf("gap_%02h", f.d), cyc - last_end - 1, 0);
                    eb.delete();
                    eb.push_back(1'b0);
                    for (int i = 0; i < 8; i++) eb.push_back(f.d[i]);
                    if (f.pm == 2'b01)      eb.push_back(^f.d);
                    else if (f.pm == 2'b10) eb.push_back(~^f.d);
                    else if (f.pm == 2'b11) eb.push_back(1'b1);
                    eb.push_back(1'b1);
                    if (f.ts) eb.push_back(1'b1);
                    for (int b = 0; b < eb.size(); b++) begin
                        v = '0;
                        for (int s = 0; s < OS; s++) begin
                            if (b != 0 || s != 0) begin
                                @(negedge clk);
                                cyc++;
                            end
                            v[s] = TxD;
                        end
                        chk($sformatf("d%02h_bit%0d", f.d, b), int'(v), eb[b] ? 32'hFFFF : 0);
                    end
                    last_end = cyc;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fdat [5];
        fdat = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h6E};
        rst = 1'b0; en = 1'b1; wr = 1'b0; data = '0; parity_mode = 2'b00; two_stop = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_txd", int'(TxD), 1);
        chk("rst_tbr", int'(tbr), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_cnt", int'(fifo_count), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Basic frame 0xA5, no parity, one stop
        push(8'hA5, 1'b0);
        wr_one(8'hA5);
        chk("a5_cnt_after_wr", int'(fifo_count), 1);
        chk("a5_busy_after_wr", int'(busy), 1);
        @(posedge clk); #1;
        chk("a5_cnt_after_pop", int'(fifo_count), 0);
        repeat (159) @(posedge clk);
        #1;
        chk("a5_busy_160", int'(busy), 1);
        @(posedge clk); #1;
        chk("a5_busy_161", int'(busy), 0);
        wait_drain("drain_a5");

        // Parity modes on 0x03
        for (int m = 1; m < 4; m++) begin
            parity_mode = 2'(m);
            send_timed($sformatf("len_pm%0d", m), 8'h03, 11);
            wait_drain($sformatf("drain_pm%0d", m));
        end
        parity_mode = 2'b00;

        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) begin
            push(fdat[i], i > 0);
            data = fdat[i];
            wr   = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("fill_ovf%0d", i), int'(overflow), 0);
        end
        wr = 1'b0;
        chk("fill_cnt", int'(fifo_count), 4);
        chk("fill_tbr", int'(tbr), 0);
        wr_one(8'hEE);
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_cnt", int'(fifo_count), 4);
        chk("ovf_tbr", int'(tbr), 0);
        @(posedge clk); #1;
        chk("ovf_clear", int'(overflow), 0);
        wait_drain("drain_fifo");

        // Three queued frames, two stop bits, contiguous
        two_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(8'h5A + 8'(i), i > 0);
            data = 8'h5A + 8'(i);
            wr   = 1'b1;
            @(posedge clk); #1;
        end
        wr = 1'b0;
        wait_drain("drain_two_stop");

        // Config change mid-frame
        parity_mode = 2'b01;
        two_stop    = 1'b0;
        push(8'h37, 1'b0);
        wr_one(8'h37);
        repeat (40) @(posedge clk);
        #1;
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        push(8'hC4, 1'b1);
        wr_one(8'hC4);
        wait_drain("drain_cfg_change");
        parity_mode = 2'b00;
        two_stop    = 1'b0;

        // Reset during data bit 3
        mon_en = 1'b0;
        wr_one(8'hF7);
        wr_one(8'h42);
        repeat (71) @(posedge clk);
        #1;
        chk("pre_rst_txd_bit3", int'(TxD), 0);
        chk("pre_rst_cnt", int'(fifo_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", int'(TxD), 1);
        chk("mid_rst_cnt", int'(fifo_count), 0);
        chk("mid_rst_tbr", int'(tbr), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_txd", int'(TxD), 1);
        chk("post_rst_busy", int'(busy), 0);
        mon_en = 1'b1;

        // Clean frame after reset: mark parity, two stops
        parity_mode = 2'b11;
        two_stop    = 1'b1;
        send_timed("len_mark_2stop", 8'h96, 12);
        wait_drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS, 8, data bits per frame; legal 5..9.
REQ-002 Parameter OVERSAMPLE, 16, en pulses per bit period; legal 2..64.
REQ-003 Parameter FIFO_DEPTH, 4, transmit FIFO entries; power of 2, 2..16.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 en  input  1  oversample tick, one clk wide; OVERSAMPLE ticks per bit.
REQ-007 data  input  DATA_BITS  character to queue; LSB transmitted first.
REQ-008 wr  input  1  write strobe; pushes data into FIFO when accepted.
REQ-009 parity_mode  input  2  00 none, 01 even, 10 odd, 11 forced-1 (mark).
REQ-010 two_stop  input  1  1 = two stop bits, 0 = one.
REQ-011 tbr  output  1  transmit buffer ready; high when FIFO not full.
REQ-012 busy  output  1  high while a frame is on the line or FIFO not empty.
REQ-013 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
REQ-015 TxD  output  1  serial line; idle high.

Function
REQ-016 FIFO write accepted when wr=1 and count<FIFO_DEPTH; a write while full is dropped and raises overflow for 1 cycle, even if a pop occurs in the same cycle.
REQ-017 Simultaneous accepted write and pop leaves count unchanged; write into an empty FIFO is poppable no earlier than the next cycle.
REQ-018 Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH nor goes below 0.
REQ-019 FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: TxD=1; if FIFO non-empty, pop head into shift register, latch parity_mode and two_stop, clear tick and bit counters, go to START next cycle.
REQ-021 Config latched at pop is used for the whole frame; changes mid-frame do not affect it.
REQ-022 Each state bit lasts exactly OVERSAMPLE en pulses; on the OVERSAMPLE-th pulse the tick counter clears and the FSM advances/shifts on that clk edge.
REQ-023 START: TxD=0 for one bit period, then DATA.
REQ-024 DATA: TxD = shift register LSB; shift right once per bit period; after DATA_BITS periods go to PARITY if parity_mode!=00, else STOP.
REQ-025 PARITY: TxD = XOR of data bits (even), its inverse (odd), or 1 (mark); one bit period, then STOP.
REQ-026 STOP: TxD=1 for 1 or 2 bit periods per latched two_stop.
REQ-027 At end of last stop bit: if FIFO non-empty, pop and enter START on the same edge (no idle gap); else go to IDLE.
REQ-028 en pulses in IDLE are ignored; en held high counts one tick per clk.
REQ-029 tbr, busy, fifo_count are registered-state functions, valid the cycle after the causing edge.
REQ-030 Frame length in bit periods = 1 + DATA_BITS + (parity?1:0) + (two_stop?2:1).

Reset
REQ-031 rst asserted: FSM to IDLE, FIFO emptied (count=0), counters cleared, TxD=1, tbr=1, busy=0, overflow=0, immediately and independent of clk.
REQ-032 rst mid-frame aborts the frame; TxD returns high without completing stop bits; queued data is discarded.

Verification
REQ-033 DATA_BITS=8, OVERSAMPLE=16, en every clk, write 0xA5, parity none, one stop -> TxD 0,1,0,1,0,0,1,0,1,1 each held 16 clk; busy low after 160 clk.
REQ-034 Write 0x03 with parity_mode=01 then 10 -> parity bit 0 then 1; with 11 -> 1; frame 11 bit periods.
REQ-035 FIFO_DEPTH=4: 5 back-to-back writes while IDLE -> first popped, 4 queued, tbr low, no overflow; 6th write -> overflow pulse, count stays 4.
REQ-036 Three queued bytes, two_stop=1 -> frames contiguous, each stop exactly 2 bit periods, start bit begins on edge after last stop tick.
REQ-037 Toggle parity_mode and two_stop mid-frame -> current frame unchanged, next frame uses new values.
REQ-038 Assert rst during DATA bit 3 -> TxD=1, count=0, tbr=1, busy=0 in same cycle; after release, new write transmits a clean frame.
